// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the SR command conditioner.
// The command-to-state mapping lives here so the FSM has one definition of it.
package sr_cmd_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE_S, DRIVE_R, GAP} state_t;
   typedef enum logic [1:0] {CMD_NONE, CMD_SET, CMD_CLR} cmd_t;

   localparam logic [7:0] DROP_MAX = 8'hFF;

   function automatic state_t drive_state(cmd_t c);
      return (c == CMD_CLR) ? DRIVE_R : DRIVE_S;
   endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchroniser, debounce counter and registered rising-edge pulse
// for one raw asynchronous request line.
module sr_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic rise
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             level_reg;
   logic             rise_reg;
   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         level_reg <= 1'b0;
         rise_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
         rise_reg  <= 1'b0;
         if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
            // This sample completes the stable run: flip now, flag 0->1 only.
            level_reg <= ~level_reg;
            rise_reg  <= ~level_reg;
            cnt_reg   <= '0;
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   assign rise = rise_reg;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Conditions raw set/clear requests into clean, mutually exclusive s/r pulses.
// Optional drop statistics are built when SR_CMD_DROP_STATS_EN is defined.
module sr_cmd_conditioner
   import sr_cmd_pkg::*;
#(
   parameter int DEB_CYCLES = 4,
   parameter int PULSE_W    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       set_raw,
   input  logic       clr_raw,
   output logic       s_out,
   output logic       r_out,
   output logic       busy,
   output logic       conflict,
   output logic [7:0] drop_cnt
);

   localparam int PW_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

   logic [1:0] raw_vec;
   logic [1:0] rise_vec;

   assign raw_vec = {clr_raw, set_raw};

   for (genvar gi = 0; gi < 2; gi++) begin : g_deb
      sr_debounce #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
         .clk  (clk),
         .rst  (rst),
         .raw  (raw_vec[gi]),
         .rise (rise_vec[gi])
      );
   end

   cmd_t            cmd;
   logic            both_rise;
   state_t          state_reg, state_next;
   logic [PW_W-1:0] pcnt_reg, pcnt_next;
   logic            pend_valid_reg, pend_valid_next;
   cmd_t            pend_cmd_reg, pend_cmd_next;
   logic            s_reg, r_reg, busy_reg, conflict_reg;
   logic            free;
   logic            consume;
   logic            store;

   // Clear wins a same-cycle collision; the set is simply discarded.
   always_comb begin
      both_rise = rise_vec[0] & rise_vec[1];
      cmd       = CMD_NONE;
      if (rise_vec[1]) begin
         cmd = CMD_CLR;
      end else if (rise_vec[0]) begin
         cmd = CMD_SET;
      end
   end

   assign free    = (state_reg == IDLE) || (state_reg == GAP);
   assign consume = free && pend_valid_reg;
   assign store   = (cmd != CMD_NONE) && ((state_reg != IDLE) || pend_valid_reg);

   always_comb begin
      state_next      = state_reg;
      pcnt_next       = pcnt_reg;
      pend_valid_next = pend_valid_reg;
      pend_cmd_next   = pend_cmd_reg;
      case (state_reg)
         IDLE, GAP: begin
            if (pend_valid_reg) begin
               state_next = drive_state(pend_cmd_reg);
               pcnt_next  = '0;
            end else if (state_reg == IDLE && cmd != CMD_NONE) begin
               state_next = drive_state(cmd);
               pcnt_next  = '0;
            end else begin
               state_next = IDLE;
            end
         end
         DRIVE_S, DRIVE_R: begin
            if (pcnt_reg == PW_W'(PULSE_W - 1)) begin
               state_next = GAP;
               pcnt_next  = '0;
            end else begin
               pcnt_next = pcnt_reg + PW_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
      // A command landing in the consuming cycle refills the slot.
      if (store) begin
         pend_valid_next = 1'b1;
         pend_cmd_next   = cmd;
      end else if (consume) begin
         pend_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= IDLE;
         pcnt_reg       <= '0;
         pend_valid_reg <= 1'b0;
         pend_cmd_reg   <= CMD_NONE;
         s_reg          <= 1'b0;
         r_reg          <= 1'b0;
         busy_reg       <= 1'b0;
         conflict_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         pcnt_reg       <= pcnt_next;
         pend_valid_reg <= pend_valid_next;
         pend_cmd_reg   <= pend_cmd_next;
         s_reg          <= (state_next == DRIVE_S);
         r_reg          <= (state_next == DRIVE_R);
         busy_reg       <= (state_next != IDLE);
         conflict_reg   <= conflict_reg | both_rise;
      end
   end

   assign s_out    = s_reg;
   assign r_out    = r_reg;
   assign busy     = busy_reg;
   assign conflict = conflict_reg;

`ifdef SR_CMD_DROP_STATS_EN
   logic       drop;
   logic [7:0] drop_reg;

   assign drop = store && pend_valid_reg && !consume;

   always_ff @(posedge clk) begin
      if (!rst) begin
         drop_reg <= 8'd0;
      end else if (drop && drop_reg != DROP_MAX) begin
         drop_reg <= drop_reg + 8'd1;
      end
   end

   assign drop_cnt = drop_reg;
`else
   assign drop_cnt = 8'd0;
`endif

endmodule
